ps2_key_receiver: RTL and testbench



---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_event_fifo.sv | 70 +++++++
 rtl/ps2_key_receiver.sv | 198 +++++++++++++++++++
 tb/tb_ps2_key_receiver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Holds the frame-state enum, the prefix byte constants and the packed key
// event that travels through the event FIFO.
package ps2_pkg;

  // Frame decoder states: waiting for a start bit, shifting data, then the
  // parity and stop bits.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  // Scan-code set 2 prefix bytes that modify the following code.
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // One decoded key event as stored in the FIFO.
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  // True for the bytes that only set a pending flag instead of producing an event.
  function automatic logic isPrefix(input logic [7:0] b);
    return (b == PS2_PREFIX_EXT) || (b == PS2_PREFIX_BRK);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Parametrised synchronous FIFO for decoded key events.
// A push while full is dropped and flagged with a one-cycle overflow strobe,
// unless a pop happens in the same cycle, in which case both proceed.
// A pop while empty is ignored. Storage is cleared on reset so the head reads
// as zero while the FIFO is empty after reset.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = $bits(ps2_event_t)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             overflow_q;
  logic             doPush;
  logic             doPop;

  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign data_o     = mem_q[rdPtr_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // still allowed when it is paired with a pop.
  always_comb begin
    doPop  = pop_i && !empty_o;
    doPush = push_i && (!full_o || doPop);
  end

  // Storage, pointers, occupancy and the registered overflow strobe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push_i && !doPush;
      if (doPush) begin
        mem_q[wrPtr_q] <= data_i;
        wrPtr_q        <= wrPtr_q + 1'b1;
      end
      if (doPop) rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronises and filters the keyboard clock,
// decodes 11-bit frames, folds E0/F0 prefixes into single key events and
// queues the events in a ready/valid FIFO.
// Optional feature macro: PS2_PARITY_CHECK_EN enables odd-parity checking;
// without it the parity bit is captured but never rejects a byte.
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 1000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          CLOCK_50,
  input  logic                          RESET,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DAT,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic [7:0]                    key_code,
  output logic                          key_ext,
  output logic                          key_break,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int TO_LIMIT = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TOW      = $clog2(TO_LIMIT + 1);
  localparam int FCW      = $clog2(FILTER_LEN + 1);

  logic [1:0]     clkSync_q;
  logic [1:0]     datSync_q;
  logic           filtClk_q;
  logic [FCW-1:0] filtCnt_q;
  logic           fall_q;

  ps2_state_e     state_q;
  logic [2:0]     bitCnt_q;
  logic [7:0]     shift_q;
  logic           parity_q;
  logic [TOW-1:0] toCnt_q;
  logic           extPend_q;
  logic           brkPend_q;
  logic           frameErr_q;

  logic           fallDat;
  logic           parityOk;
  logic           byteOk;
  logic           timeoutHit;
  logic           pushEvent;
  ps2_event_t     pushData;
  ps2_event_t     headData;
  logic           fifoFull;
  logic           fifoEmpty;

  // Two-stage synchronisers; both lines idle high so they reset to 1.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      clkSync_q <= 2'b11;
      datSync_q <= 2'b11;
    end else begin
      clkSync_q <= {clkSync_q[0], PS2_CLK};
      datSync_q <= {datSync_q[0], PS2_DAT};
    end
  end

  // Glitch filter: the filtered clock follows the synchronised clock only
  // after FILTER_LEN consecutive differing samples; a 1->0 change strobes fall.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      filtClk_q <= 1'b1;
      filtCnt_q <= '0;
      fall_q    <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (clkSync_q[1] != filtClk_q) begin
        if (filtCnt_q == FCW'(FILTER_LEN - 1)) begin
          filtClk_q <= clkSync_q[1];
          filtCnt_q <= '0;
          fall_q    <= !clkSync_q[1];
        end else begin
          filtCnt_q <= filtCnt_q + 1'b1;
        end
      end else begin
        filtCnt_q <= '0;
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  // Odd parity across the eight data bits and the parity bit.
  assign parityOk = ^{shift_q, parity_q};
`else
  // The parity bit is still captured but never rejects a byte.
  assign parityOk = (^{shift_q, parity_q}) | 1'b1;
`endif

  // Byte acceptance happens in the stop-bit fall cycle; prefixes only update
  // the pending flags, everything else becomes an event.
  always_comb begin
    fallDat       = datSync_q[1];
    byteOk        = fall_q && (state_q == ST_STOP) && fallDat && parityOk;
    timeoutHit    = (state_q != ST_IDLE) && !fall_q && (toCnt_q == TOW'(TO_LIMIT));
    pushEvent     = byteOk && !isPrefix(shift_q);
    pushData      = '0;
    pushData.ext  = extPend_q;
    pushData.brk  = brkPend_q;
    pushData.code = shift_q;
  end

  // Frame FSM with timeout, prefix tracking and the registered error strobe.
  // A timeout abandons the partial byte but keeps any pending prefix flags.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      toCnt_q    <= '0;
      extPend_q  <= 1'b0;
      brkPend_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      frameErr_q <= 1'b0;
      if (state_q == ST_IDLE || fall_q || timeoutHit) toCnt_q <= '0;
      else toCnt_q <= toCnt_q + 1'b1;

      if (timeoutHit) begin
        state_q    <= ST_IDLE;
        frameErr_q <= 1'b1;
      end else if (fall_q) begin
        case (state_q)
          ST_IDLE: begin
            if (!fallDat) begin
              state_q  <= ST_DATA;
              bitCnt_q <= '0;
            end else begin
              frameErr_q <= 1'b1;
            end
          end
          ST_DATA: begin
            shift_q  <= {fallDat, shift_q[7:1]};
            bitCnt_q <= bitCnt_q + 1'b1;
            if (bitCnt_q == 3'd7) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
            parity_q <= fallDat;
            state_q  <= ST_STOP;
          end
          ST_STOP: begin
            state_q <= ST_IDLE;
            if (byteOk) begin
              if (shift_q == PS2_PREFIX_EXT) begin
                extPend_q <= 1'b1;
              end else if (shift_q == PS2_PREFIX_BRK) begin
                brkPend_q <= 1'b1;
              end else begin
                extPend_q <= 1'b0;
                brkPend_q <= 1'b0;
              end
            end else begin
              frameErr_q <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ps2_event_t))
  ) u_fifo (
    .clk_i      (CLOCK_50),
    .rst_i      (RESET),
    .push_i     (pushEvent),
    .data_i     (pushData),
    .pop_i      (key_ready),
    .data_o     (headData),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .count_o    (fifo_count),
    .overflow_o (overflow)
  );

  assign key_valid = !fifoEmpty;
  assign key_code  = headData.code;
  assign key_ext   = headData.ext;
  assign key_break = headData.brk;
  assign frame_err = frameErr_q;

  // Full is implied by fifo_count; kept only as a named FIFO status.
  logic unusedFull;
  assign unusedFull = fifoFull;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed testbench for ps2_key_receiver. The clock runs at 10 MHz
// (CLK_HZ=10_000_000) so a PS/2 bit of 200 cycles is 20 us; a 1 us glitch
// is 10 cycles, shorter than FILTER_LEN=20.
module tb_ps2_key_receiver;

  localparam int FIFO_DEPTH = 8;
  localparam int HALF_BIT   = 100;

  logic       CLOCK_50;
  logic       RESET;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic [3:0] fifo_count;
  logic       frame_err;
  logic       overflow;

  int checkCount;
  int failCount;
  int errPulses;
  int ovfPulses;
  int maxCount;
  logic [9:0] evQ[$];

  ps2_key_receiver #(
    .CLK_HZ     (10_000_000),
    .FILTER_LEN (20),
    .TIMEOUT_US (1000),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .PS2_CLK    (PS2_CLK),
    .PS2_DAT    (PS2_DAT),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_break  (key_break),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  // Free-running 10 MHz system clock.
  initial CLOCK_50 = 1'b0;
  always #50 CLOCK_50 = ~CLOCK_50;

  // Watch the outputs just after each falling edge: count error and overflow
  // pulses, track peak occupancy and log every event handed to the consumer.
  always @(negedge CLOCK_50) begin
    #1;
    if (frame_err) errPulses++;
    if (overflow) ovfPulses++;
    if (int'(fifo_count) > maxCount) maxCount = int'(fifo_count);
    if (key_valid && key_ready) evQ.push_back({key_ext, key_break, key_code});
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // One PS/2 bit: data set while the clock is high, then a low pulse.
  task automatic sendBit(input logic b);
    PS2_DAT = b;
    waitCycles(HALF_BIT / 2);
    PS2_CLK = 1'b0;
    waitCycles(HALF_BIT);
    PS2_CLK = 1'b1;
    waitCycles(HALF_BIT / 2);
  endtask

  // Full frame with either correct (odd) or deliberately wrong parity.
  task automatic applyStimulus(input logic [7:0] code, input bit badParity);
    logic par;
    par = badParity ? ^code : ~^code;
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(code[i]);
    sendBit(par);
    sendBit(1'b1);
    PS2_DAT = 1'b1;
    waitCycles(2 * HALF_BIT);
  endtask

  // Start bit plus the first nbits-1 data bits, then leave the line idle.
  task automatic sendPartial(input int nbits, input logic [7:0] code);
    sendBit(1'b0);
    for (int i = 0; i < nbits - 1; i++) sendBit(code[i]);
    PS2_DAT = 1'b1;
  endtask

  function automatic logic [9:0] evAt(input int i);
    return (evQ.size() > i) ? evQ[i] : 10'h3FF;
  endfunction

  initial begin
    logic [7:0] codes [9];
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    checkCount = 0;
    failCount  = 0;
    errPulses  = 0;
    ovfPulses  = 0;
    maxCount   = 0;
    RESET      = 1'b1;
    PS2_CLK    = 1'b1;
    PS2_DAT    = 1'b1;
    key_ready  = 1'b1;
    waitCycles(5);

    checkOutput("rst_valid", key_valid, 0);
    checkOutput("rst_code", key_code, 8'h00);
    checkOutput("rst_ext", key_ext, 0);
    checkOutput("rst_break", key_break, 0);
    checkOutput("rst_count", fifo_count, 0);
    checkOutput("rst_ferr", frame_err, 0);
    checkOutput("rst_ovf", overflow, 0);
    RESET = 1'b0;
    waitCycles(50);

    // Plain make code.
    evQ.delete(); errPulses = 0;
    applyStimulus(8'h1C, 0);
    checkOutput("t1_events", evQ.size(), 1);
    checkOutput("t1_event", evAt(0), {2'b00, 8'h1C});
    checkOutput("t1_ferr", errPulses, 0);
    checkOutput("t1_count", fifo_count, 0);

    // Extended release folds three bytes into one event.
    evQ.delete(); maxCount = 0;
    applyStimulus(8'hE0, 0);
    applyStimulus(8'hF0, 0);
    checkOutput("t2_prefix_none", evQ.size(), 0);
    applyStimulus(8'h75, 0);
    checkOutput("t2_events", evQ.size(), 1);
    checkOutput("t2_event", evAt(0), {2'b11, 8'h75});
    checkOutput("t2_peak", maxCount, 1);

    // Even parity byte.
    evQ.delete(); errPulses = 0;
    applyStimulus(8'h16, 1);
`ifdef PS2_PARITY_CHECK_EN
    checkOutput("t3_ferr", errPulses, 1);
    checkOutput("t3_events", evQ.size(), 0);
`else
    checkOutput("t3_ferr", errPulses, 0);
    checkOutput("t3_event", evAt(0), {2'b00, 8'h16});
`endif

    // Truncated frame followed by 1.2 ms of silence, then a good frame.
    evQ.delete(); errPulses = 0;
    sendPartial(5, 8'h5A);
    waitCycles(12000);
    checkOutput("t4_timeout_ferr", errPulses, 1);
    checkOutput("t4_timeout_events", evQ.size(), 0);
    applyStimulus(8'h1E, 0);
    checkOutput("t4_event", evAt(0), {2'b00, 8'h1E});
    checkOutput("t4_ferr_after", errPulses, 1);

    // Nine codes with no consumer: eight stored, one dropped.
    evQ.delete(); ovfPulses = 0;
    key_ready = 1'b0;
    for (int i = 0; i < 9; i++) applyStimulus(codes[i], 0);
    checkOutput("t5_count", fifo_count, FIFO_DEPTH);
    checkOutput("t5_ovf", ovfPulses, 1);
    checkOutput("t5_valid", key_valid, 1);
    checkOutput("t5_head", {key_ext, key_break, key_code}, {2'b00, 8'h15});
    key_ready = 1'b1;
    waitCycles(20);
    checkOutput("t5_drained", evQ.size(), FIFO_DEPTH);
    for (int i = 0; i < FIFO_DEPTH; i++)
      checkOutput($sformatf("t5_order%0d", i), evAt(i), {2'b00, codes[i]});
    checkOutput("t5_empty", fifo_count, 0);

    // 1 us clock glitch with data high must not register as a start bit.
    evQ.delete(); errPulses = 0;
    PS2_DAT = 1'b1;
    PS2_CLK = 1'b0;
    waitCycles(10);
    PS2_CLK = 1'b1;
    waitCycles(300);
    checkOutput("t6_glitch_ferr", errPulses, 0);
    checkOutput("t6_glitch_events", evQ.size(), 0);
    applyStimulus(8'h29, 0);
    checkOutput("t6_event", evAt(0), {2'b00, 8'h29});

    // Reset mid-frame with one event queued.
    evQ.delete();
    key_ready = 1'b0;
    applyStimulus(8'h4D, 0);
    checkOutput("t7_queued", fifo_count, 1);
    sendPartial(4, 8'hFF);
    RESET = 1'b1;
    waitCycles(3);
    checkOutput("t7_rst_valid", key_valid, 0);
    checkOutput("t7_rst_count", fifo_count, 0);
    checkOutput("t7_rst_code", key_code, 8'h00);
    checkOutput("t7_rst_ferr", frame_err, 0);
    RESET = 1'b0;
    key_ready = 1'b1;
    waitCycles(50);
    evQ.delete(); errPulses = 0;
    applyStimulus(8'h45, 0);
    checkOutput("t7_event", evAt(0), {2'b00, 8'h45});
    checkOutput("t7_events", evQ.size(), 1);
    checkOutput("t7_ferr", errPulses, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, failCount);
    $finish;
  end

endmodule
